// File: rtl/delay_pipe.sv
// Multi-lane, valid-tracked delay line with runtime-selectable tap (0..MAX_LATENCY),
// clock-enable stall, synchronous flush and an in-flight occupancy flag.
module delay_pipe #(
  parameter int MAX_LATENCY = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int CHANNELS    = 1,
  parameter int LAT_WIDTH   = 4,
  parameter int GATE_DATA   = 0
) (
  input  logic                           clkIn,
  input  logic                           rstIn,
  input  logic                           enIn,
  input  logic                           flushIn,
  input  logic [LAT_WIDTH-1:0]           latencyIn,
  input  logic                           validIn,
  input  logic [CHANNELS*DATA_WIDTH-1:0] dataIn,
  output logic                           validOut,
  output logic [CHANNELS*DATA_WIDTH-1:0] dataOut,
  output logic                           busyOut
);

  localparam int                   W       = CHANNELS * DATA_WIDTH;
  localparam logic [LAT_WIDTH-1:0] MAX_LAT = LAT_WIDTH'(MAX_LATENCY);

  logic [MAX_LATENCY-1:0]        vld_q, vld_d;
  logic [MAX_LATENCY-1:0][W-1:0] data_q, data_d;
  logic [LAT_WIDTH-1:0]          leff;
  logic                          tap_vld;
  logic [W-1:0]                  tap_data;
  logic                          busy;

  function automatic logic [LAT_WIDTH-1:0] clamp_lat(input logic [LAT_WIDTH-1:0] lat);
    return (lat > MAX_LAT) ? MAX_LAT : lat;
  endfunction

  function automatic logic [W-1:0] gate_data(input logic vld, input logic [W-1:0] d);
    return ((GATE_DATA != 0) && !vld) ? '0 : d;
  endfunction

  // Stage update: flush clears valid only and freezes data; advance shifts both.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (flushIn) begin
      vld_d = '0;
    end else if (enIn) begin
      vld_d[0]  = validIn;
      data_d[0] = dataIn;
      for (int k = 1; k < MAX_LATENCY; k++) begin
        vld_d[k]  = vld_q[k-1];
        data_d[k] = data_q[k-1];
      end
    end
  end

  always_ff @(posedge clkIn) begin
    if (!rstIn) begin
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  // Output tap: latency 0 bypasses storage entirely, so enIn/flushIn never touch it.
  always_comb begin
    leff     = clamp_lat(latencyIn);
    tap_vld  = validIn;
    tap_data = dataIn;
    busy     = 1'b0;
    for (int k = 0; k < MAX_LATENCY; k++) begin
      if (leff == LAT_WIDTH'(k + 1)) begin
        tap_vld  = vld_q[k];
        tap_data = data_q[k];
      end
      if (LAT_WIDTH'(k) < leff) begin
        busy = busy | vld_q[k];
      end
    end
    validOut = tap_vld;
    dataOut  = gate_data(tap_vld, tap_data);
    busyOut  = busy;
  end

endmodule

// File: tb/tb_delay_pipe.sv
// Bench for delay_pipe: directed table, hand-written corner sequences and a
// randomized run against a queue-based reference model.
module tb_delay_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0, en = 1'b1, fl = 1'b0, vin = 1'b0;
  logic [3:0]  lat = 4'd0;
  logic [31:0] din = '0;
  logic [63:0] din2 = '0;
  logic        vout, busy, vout2, busy2;
  logic [31:0] dout;
  logic [63:0] dout2;

  int total = 0;
  int passed = 0;

  delay_pipe #(.MAX_LATENCY(8), .DATA_WIDTH(32), .CHANNELS(1), .LAT_WIDTH(4), .GATE_DATA(0)) dut (
    .clkIn(clk), .rstIn(rst_n), .enIn(en), .flushIn(fl), .latencyIn(lat),
    .validIn(vin), .dataIn(din), .validOut(vout), .dataOut(dout), .busyOut(busy)
  );

  delay_pipe #(.MAX_LATENCY(8), .DATA_WIDTH(16), .CHANNELS(4), .LAT_WIDTH(4), .GATE_DATA(1)) dut_lanes (
    .clkIn(clk), .rstIn(rst_n), .enIn(en), .flushIn(fl), .latencyIn(lat),
    .validIn(vin), .dataIn(din2), .validOut(vout2), .dataOut(dout2), .busyOut(busy2)
  );

  // Reference model: history of accepted beats, newest first, MAX_LATENCY deep.
  typedef struct {
    logic        v;
    logic [31:0] d1;
    logic [63:0] d2;
  } beat_t;
  beat_t hist[$];

  typedef struct {
    logic        r, e, f;
    logic [3:0]  l;
    logic        v;
    logic [31:0] d;
    bit          chk;
    logic        ev;
    logic [31:0] ed;
    logic        eb;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic e, input logic f, input logic [3:0] l,
                       input logic v, input logic [31:0] d, input logic [63:0] d2);
    @(negedge clk);
    rst_n = r; en = e; fl = f; lat = l; vin = v; din = d; din2 = d2;
    #1;
  endtask

  task automatic commit();
    beat_t b;
    @(posedge clk);
    if (!rst_n) begin
      hist.delete();
      b.v = 1'b0; b.d1 = '0; b.d2 = '0;
      repeat (8) hist.push_back(b);
    end else if (fl) begin
      foreach (hist[i]) hist[i].v = 1'b0;
    end else if (en) begin
      b.v = vin; b.d1 = din; b.d2 = din2;
      hist.push_front(b);
      void'(hist.pop_back());
    end
  endtask

  task automatic model_check();
    int          leff;
    logic        ev, eb;
    logic [31:0] ed1;
    logic [63:0] ed2;
    leff = (lat > 4'd8) ? 8 : int'(lat);
    eb = 1'b0;
    if (leff == 0) begin
      ev = vin; ed1 = din; ed2 = din2;
    end else begin
      ev = hist[leff-1].v; ed1 = hist[leff-1].d1; ed2 = hist[leff-1].d2;
    end
    for (int i = 0; i < leff; i++) eb = eb | hist[i].v;
    check("rand_valid", vout, ev);
    check("rand_data", dout, ed1);
    check("rand_busy", busy, eb);
    check("rand_lanes_valid", vout2, ev);
    check("rand_lanes_data", dout2, ev ? ed2 : 64'h0);
  endtask

  task automatic add(input logic r, input logic e, input logic f, input logic [3:0] l,
                     input logic v, input logic [31:0] d, input bit c,
                     input logic ev, input logic [31:0] ed, input logic eb);
    vec_t t;
    t.r = r; t.e = e; t.f = f; t.l = l; t.v = v; t.d = d;
    t.chk = c; t.ev = ev; t.ed = ed; t.eb = eb;
    vecs.push_back(t);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b1, 1'b0, 4'd8, 1'b0, '0, '0);
    commit();
  endtask

  initial begin
    logic        ev, eb, v, e, f;
    logic [31:0] d, ed;
    logic [63:0] d2;

    // Reset with a valid all-ones beat held at the input, then eight quiet cycles.
    for (int i = 0; i < 2; i++) add(1'b0, 1'b1, 1'b0, 4'd8, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 8; i++) add(1'b1, 1'b1, 1'b0, 4'd8, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    // Latency 8: three beats in cycles 0..2 emerge in cycles 8..10.
    for (int c = 0; c < 12; c++) begin
      d  = (c == 0) ? 32'h11 : (c == 1) ? 32'h22 : (c == 2) ? 32'h33 : 32'h0;
      ed = (c == 8) ? 32'h11 : (c == 9) ? 32'h22 : (c == 10) ? 32'h33 : 32'h0;
      add(1'b1, 1'b1, 1'b0, 4'd8, c < 3, d, 1'b1, (c >= 8) && (c <= 10), ed, (c >= 1) && (c <= 10));
    end

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].e, vecs[i].f, vecs[i].l, vecs[i].v, vecs[i].d, '0);
      if (vecs[i].chk) begin
        check($sformatf("table%0d_valid", i), vout, vecs[i].ev);
        check($sformatf("table%0d_data", i), dout, vecs[i].ed);
        check($sformatf("table%0d_busy", i), busy, vecs[i].eb);
      end
      commit();
    end

    // Stall: beat at cycle 0, enIn low in cycles 2..4 with junk beats offered.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      e = !((c >= 2) && (c <= 4));
      v = (c == 0) || !e;
      d = (c == 0) ? 32'hA5 : (!e ? 32'hDEAD : 32'h0);
      drive(1'b1, e, 1'b0, 4'd4, v, d, '0);
      check($sformatf("stall_valid_c%0d", c), vout, c == 7);
      check($sformatf("stall_data_c%0d", c), dout, (c == 7) ? 32'hA5 : 32'h0);
      check($sformatf("stall_busy_c%0d", c), busy, (c >= 1) && (c <= 7));
      commit();
    end

    // Flush: five beats in cycles 0..4, flush coincides with the fifth.
    do_reset();
    for (int c = 0; c < 16; c++) begin
      drive(1'b1, 1'b1, c == 4, 4'd6, c <= 4, 32'h100 + c, '0);
      check($sformatf("flush_valid_c%0d", c), vout, 1'b0);
      check($sformatf("flush_busy_c%0d", c), busy, (c >= 1) && (c <= 4));
      commit();
    end

    // Latency 0 passthrough, unaffected by enIn/flushIn, busy stays low.
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 32'h5, 64'h5);
    check("l0_valid", vout, 1'b1);
    check("l0_data", dout, 32'h5);
    check("l0_busy", busy, 1'b0);
    check("l0_lanes_data", dout2, 64'h5);
    commit();
    drive(1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 32'h77, 64'h77);
    check("l0_stall_flush_valid", vout, 1'b1);
    check("l0_stall_flush_data", dout, 32'h77);
    check("l0_stored_busy", busy, 1'b0);
    commit();
    drive(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 32'h99, 64'hABCD);
    check("l0_invalid_data", dout, 32'h99);
    check("l0_gated_data", dout2, 64'h0);
    commit();

    // Out-of-range latency clamps to 8.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 1'b1, 1'b0, 4'd12, c == 0, (c == 0) ? 32'hCAFE : 32'h0, '0);
      check($sformatf("clamp_valid_c%0d", c), vout, c == 8);
      check($sformatf("clamp_data_c%0d", c), dout, (c == 8) ? 32'hCAFE : 32'h0);
      commit();
    end

    // Four 16-bit lanes with output gating at latency 3.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      d2 = (c == 0) ? 64'h4444_3333_2222_1111 : 64'hFFFF_EEEE_DDDD_CCCC;
      drive(1'b1, 1'b1, 1'b0, 4'd3, c == 0, '0, d2);
      check($sformatf("lanes_valid_c%0d", c), vout2, c == 3);
      check($sformatf("lanes_data_c%0d", c), dout2, (c == 3) ? 64'h4444_3333_2222_1111 : 64'h0);
      commit();
    end

    // Randomized run against the reference model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      e  = ($urandom_range(0, 3) != 0);
      f  = ($urandom_range(0, 15) == 0);
      v  = $urandom_range(0, 1);
      d  = $urandom;
      d2 = {$urandom, $urandom};
      drive($urandom_range(0, 31) != 0, e, f, 4'($urandom_range(0, 15)), v, d, d2);
      model_check();
      commit();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
